// File: rtl/spdot_job_sched_if.sv
// Command, core-control, response and statistics bundle of the spdot job scheduler.
// Pure wiring: no state, no latency.
// Backpressure: per-requester cmd_valid/cmd_ready and rsp_valid/rsp_ready handshakes.
interface spdot_job_sched_if #(
  parameter int N_REQ = 2,
  parameter int TAG_W = 8
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // command side, one lane per requester
  logic [N_REQ-1:0]       cmd_valid;
  logic [N_REQ-1:0]       cmd_ready;
  logic [N_REQ*16-1:0]    cmd_m_rows;
  logic [N_REQ*16-1:0]    cmd_head_dim;
  logic [N_REQ*16-1:0]    cmd_s_tokens;
  logic [N_REQ*TAG_W-1:0] cmd_tag;

  // compute core control
  logic                   core_start;
  logic [15:0]            core_m_rows;
  logic [15:0]            core_head_dim;
  logic [15:0]            core_s_tokens;
  logic                   core_busy;
  logic                   core_done;
  logic [63:0]            core_checksum;

  // response channel
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [TAG_W-1:0]       rsp_tag;
  logic [63:0]            rsp_checksum;
  logic [1:0]             rsp_status;

  // statistics
  logic [31:0]            stat_jobs;
  logic [15:0]            stat_timeouts;

  // scheduler side
  modport master (
    input  cmd_valid, cmd_m_rows, cmd_head_dim, cmd_s_tokens, cmd_tag,
    output cmd_ready,
    output core_start, core_m_rows, core_head_dim, core_s_tokens,
    input  core_busy, core_done, core_checksum,
    output rsp_valid, rsp_id, rsp_tag, rsp_checksum, rsp_status,
    input  rsp_ready,
    output stat_jobs, stat_timeouts
  );

  // requesters, core and response consumer
  modport slave (
    output cmd_valid, cmd_m_rows, cmd_head_dim, cmd_s_tokens, cmd_tag,
    input  cmd_ready,
    input  core_start, core_m_rows, core_head_dim, core_s_tokens,
    output core_busy, core_done, core_checksum,
    input  rsp_valid, rsp_id, rsp_tag, rsp_checksum, rsp_status,
    output rsp_ready,
    input  stat_jobs, stat_timeouts
  );
endinterface

// File: rtl/spdot_job_sched.sv
// Round-robin job scheduler sharing one spdot_bsr core between N_REQ requesters, with watchdog.
// Latency: accept->core_start 1 cycle; core_done->rsp_valid 1 cycle; zero-size accept->rsp_valid 1 cycle.
// Backpressure: one job in flight; cmd_ready only in IDLE; response held until rsp_ready.
module spdot_job_sched #(
  parameter int          N_REQ       = 2,
  parameter int          TAG_W       = 8,
  parameter int          WDOG_W      = 24,
  parameter int unsigned TIMEOUT_CYC = 32'd1 << 20
) (
  input  logic           clk,
  input  logic           rstn,
  spdot_job_sched_if.master bus
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYC - 32'd1);
  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_ZERO    = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP, S_FLUSH} state_t;

  state_t            state_q;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WDOG_W-1:0] wdog_q;
  logic              core_start_q;
  logic [15:0]       core_m_rows_q, core_head_dim_q, core_s_tokens_q;
  logic              rsp_valid_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [TAG_W-1:0]  rsp_tag_q;
  logic [63:0]       rsp_checksum_q;
  logic [1:0]        rsp_status_q;
  logic [31:0]       stat_jobs_q;
  logic [15:0]       stat_timeouts_q;

  logic              win_vld;
  logic [ID_W-1:0]   win_idx;
  int                scan_r;
  logic [N_REQ-1:0]  cmd_ready_c;
  logic [15:0]       sel_m_rows, sel_head_dim, sel_s_tokens;
  logic [TAG_W-1:0]  sel_tag;
  logic              sel_zero;

  // Round-robin pick: scan downwards so the requester closest to rr_ptr overwrites the others.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    scan_r  = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_r = int'(rr_ptr_q) + k;
      if (scan_r >= N_REQ) scan_r = scan_r - N_REQ;
      if (bus.cmd_valid[scan_r]) begin
        win_vld = 1'b1;
        win_idx = ID_W'(scan_r);
      end
    end
  end

  // Grant is combinational in IDLE only; held low while reset is asserted so every output reads 0.
  always_comb begin
    cmd_ready_c = '0;
    if (rstn && state_q == S_IDLE && win_vld) cmd_ready_c[win_idx] = 1'b1;
  end

  // Next pointer starts the following scan just after the winner.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (win_vld) rr_ptr_d = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
  end

  assign sel_m_rows   = bus.cmd_m_rows[16*win_idx +: 16];
  assign sel_head_dim = bus.cmd_head_dim[16*win_idx +: 16];
  assign sel_s_tokens = bus.cmd_s_tokens[16*win_idx +: 16];
  assign sel_tag      = bus.cmd_tag[TAG_W*win_idx +: TAG_W];
  assign sel_zero     = (sel_m_rows == '0) || (sel_head_dim == '0) || (sel_s_tokens == '0);

  // Job FSM: accept, launch, watch the core, hand back the response, drain a timed-out core.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= S_IDLE;
      rr_ptr_q        <= '0;
      wdog_q          <= '0;
      core_start_q    <= 1'b0;
      core_m_rows_q   <= '0;
      core_head_dim_q <= '0;
      core_s_tokens_q <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_id_q        <= '0;
      rsp_tag_q       <= '0;
      rsp_checksum_q  <= '0;
      rsp_status_q    <= '0;
      stat_jobs_q     <= '0;
      stat_timeouts_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_vld) begin
            rr_ptr_q        <= rr_ptr_d;
            core_m_rows_q   <= sel_m_rows;
            core_head_dim_q <= sel_head_dim;
            core_s_tokens_q <= sel_s_tokens;
            rsp_id_q        <= win_idx;
            rsp_tag_q       <= sel_tag;
            if (sel_zero) begin
              rsp_valid_q    <= 1'b1;
              rsp_status_q   <= ST_ZERO;
              rsp_checksum_q <= '0;
              state_q        <= S_RESP;
            end else begin
              core_start_q <= 1'b1;
              state_q      <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          core_start_q <= 1'b0;
          wdog_q       <= '0;
          state_q      <= S_WAIT;
        end
        S_WAIT: begin
          wdog_q <= wdog_q + 1'b1;
          // done takes priority over a watchdog expiring in the same cycle
          if (bus.core_done) begin
            rsp_valid_q    <= 1'b1;
            rsp_status_q   <= ST_OK;
            rsp_checksum_q <= bus.core_checksum;
            state_q        <= S_RESP;
          end else if (TIMEOUT_CYC != 0 && wdog_q == WDOG_LIMIT) begin
            rsp_valid_q    <= 1'b1;
            rsp_status_q   <= ST_TIMEOUT;
            rsp_checksum_q <= '0;
            state_q        <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            stat_jobs_q <= stat_jobs_q + 32'd1;
            if (rsp_status_q == ST_TIMEOUT && stat_timeouts_q != 16'hFFFF)
              stat_timeouts_q <= stat_timeouts_q + 16'd1;
            // a timed-out core may still be running; keep it from seeing a new start
            state_q <= (rsp_status_q == ST_TIMEOUT && bus.core_busy) ? S_FLUSH : S_IDLE;
          end
        end
        S_FLUSH: begin
          if (!bus.core_busy) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready     = cmd_ready_c;
  assign bus.core_start    = core_start_q;
  assign bus.core_m_rows   = core_m_rows_q;
  assign bus.core_head_dim = core_head_dim_q;
  assign bus.core_s_tokens = core_s_tokens_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_id        = rsp_id_q;
  assign bus.rsp_tag       = rsp_tag_q;
  assign bus.rsp_checksum  = rsp_checksum_q;
  assign bus.rsp_status    = rsp_status_q;
  assign bus.stat_jobs     = stat_jobs_q;
  assign bus.stat_timeouts = stat_timeouts_q;
endmodule

// File: tb/tb_spdot_job_sched.sv
// Bench for spdot_job_sched: directed table, hand-written corner sequences, random jobs vs a reference model.
// A behavioural core model drives busy/done; expected responses come from the job rules, not the RTL.
// Response backpressure is exercised with randomized rsp_ready stalls.
module tb_spdot_job_sched;
  localparam int N    = 2;
  localparam int TW   = 8;
  localparam int TMO  = 16;
  localparam int ID_W = (N > 1) ? $clog2(N) : 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  spdot_job_sched_if #(.N_REQ(N), .TAG_W(TW)) bus ();

  spdot_job_sched #(.N_REQ(N), .TAG_W(TW), .WDOG_W(24), .TIMEOUT_CYC(TMO)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- core model: done D cycles after start, busy until the cycle after done
  int          nxt_delay = 1;
  logic [63:0] nxt_chk = '0;
  int          n_starts = 0;

  initial begin
    int          cnt, cur_d;
    logic        active;
    logic [63:0] cur_c;
    active = 1'b0; cnt = 0; cur_d = 0; cur_c = '0;
    bus.core_busy = 1'b0; bus.core_done = 1'b0; bus.core_checksum = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        active = 1'b0; bus.core_busy = 1'b0; bus.core_done = 1'b0;
      end else begin
        bus.core_done = 1'b0;
        bus.core_checksum = {$urandom, $urandom};
        if (active) begin
          cnt++;
          if (cnt == cur_d) begin
            bus.core_done = 1'b1;
            bus.core_checksum = cur_c;
          end else if (cnt > cur_d) begin
            active = 1'b0;
            bus.core_busy = 1'b0;
          end
        end
        if (bus.core_start) begin
          active = 1'b1; bus.core_busy = 1'b1; cnt = 0;
          cur_d = nxt_delay; cur_c = nxt_chk; n_starts++;
        end
      end
    end
  end

  // ---------------- grant invariants every cycle
  int viol = 0;
  initial forever begin
    @(posedge clk); #3;
    if (rstn) begin
      if ($countones(bus.cmd_ready) > 1) viol++;
      if ((bus.cmd_ready & ~bus.cmd_valid) != '0) viol++;
      if (bus.cmd_ready != '0 && bus.core_busy) viol++;
    end
  end

  // ---------------- requester state and reference model
  bit          pend [N];
  logic [15:0] jm [N], jd [N], js [N];
  logic [TW-1:0] jt [N];
  int          jdel [N];
  logic [63:0] jchk [N];
  int          mrr = 0;
  int          exp_jobs = 0, exp_tmo = 0;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive_cmds();
    for (int r = 0; r < N; r++) begin
      bus.cmd_valid[r]              = pend[r];
      bus.cmd_m_rows[16*r +: 16]    = jm[r];
      bus.cmd_head_dim[16*r +: 16]  = jd[r];
      bus.cmd_s_tokens[16*r +: 16]  = js[r];
      bus.cmd_tag[TW*r +: TW]       = jt[r];
    end
  endtask

  task automatic set_job(input int r, input logic [15:0] m, d, s, input logic [TW-1:0] tag,
                         input int dly, input logic [63:0] c);
    pend[r] = 1'b1; jm[r] = m; jd[r] = d; js[r] = s; jt[r] = tag; jdel[r] = dly; jchk[r] = c;
  endtask

  task automatic serve_one(input int stall, output int got_id, output logic [1:0] got_st,
                           output logic [63:0] got_chk);
    int w, n, starts0, hold_bad, exp_lat;
    logic zero;
    logic [1:0] est;
    logic [63:0] echk;
    logic [ID_W+TW+64+2-1:0] snap;
    got_id = -1; got_st = 2'd3; got_chk = '1;
    drive_cmds(); #1;
    n = 0;
    while (bus.cmd_ready == '0 && n < 200) begin
      step(); drive_cmds(); #1; n++;
    end
    if (bus.cmd_ready == '0) begin
      n_checks++; n_errors++;
      $display("FAIL accept_wait: no cmd_ready within 200 cycles, cmd_valid=%b", bus.cmd_valid);
      return;
    end
    w = -1;
    for (int k = 0; k < N; k++) if (w < 0 && pend[(mrr + k) % N]) w = (mrr + k) % N;
    if (w < 0) w = 0;
    check("grant", 64'(bus.cmd_ready), 64'(1) << w);
    zero = (jm[w] == 0) || (jd[w] == 0) || (js[w] == 0);
    est  = zero ? 2'd1 : (jdel[w] <= TMO) ? 2'd0 : 2'd2;
    echk = (est == 2'd0) ? jchk[w] : 64'd0;
    exp_lat = zero ? 0 : (est == 2'd0) ? jdel[w] + 1 : TMO + 1;
    nxt_delay = jdel[w]; nxt_chk = jchk[w];
    mrr = (w + 1) % N; pend[w] = 1'b0; starts0 = n_starts;
    step(); drive_cmds(); #1;
    check("ready_after_accept", 64'(bus.cmd_ready), 64'd0);
    if (zero) check("zero_no_start", 64'(bus.core_start), 64'd0);
    else begin
      check("start_pulse", 64'(bus.core_start), 64'd1);
      check("core_cfg", 64'({bus.core_m_rows, bus.core_head_dim, bus.core_s_tokens}),
            64'({jm[w], jd[w], js[w]}));
    end
    n = 0;
    while (!bus.rsp_valid && n < TMO + 50) begin step(); #1; n++; end
    check("rsp_latency", 64'(n), 64'(exp_lat));
    snap = {bus.rsp_id, bus.rsp_tag, bus.rsp_checksum, bus.rsp_status};
    hold_bad = 0;
    for (int i = 0; i < stall; i++) begin
      step(); #1;
      if ({bus.rsp_id, bus.rsp_tag, bus.rsp_checksum, bus.rsp_status} !== snap ||
          !bus.rsp_valid || bus.cmd_ready != '0) hold_bad++;
    end
    if (stall > 0) check("rsp_hold", 64'(hold_bad), 64'd0);
    if (!zero) check("cfg_stable", 64'({bus.core_m_rows, bus.core_head_dim, bus.core_s_tokens}),
                     64'({jm[w], jd[w], js[w]}));
    bus.rsp_ready = 1'b1; #1;
    check("rsp_id", 64'(bus.rsp_id), 64'(w));
    check("rsp_tag", 64'(bus.rsp_tag), 64'(jt[w]));
    check("rsp_chk", bus.rsp_checksum, echk);
    check("rsp_status", 64'(bus.rsp_status), 64'(est));
    check("core_starts", 64'(n_starts - starts0), zero ? 64'd0 : 64'd1);
    got_id = int'(bus.rsp_id); got_st = bus.rsp_status; got_chk = bus.rsp_checksum;
    step();
    bus.rsp_ready = 1'b0;
    exp_jobs++;
    if (est == 2'd2) exp_tmo++;
    check("rsp_valid_drop", 64'(bus.rsp_valid), 64'd0);
    check("stat_jobs", 64'(bus.stat_jobs), 64'(exp_jobs));
    check("stat_timeouts", 64'(bus.stat_timeouts), 64'(exp_tmo));
  endtask

  // ---------------- directed table with hand-derived expectations
  typedef struct {
    int          req;
    logic [15:0] m, d, s;
    logic [7:0]  tag;
    int          dly;
    logic [63:0] cchk;
    int          stall;
    logic [1:0]  est;
    logic [63:0] echk;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int gid, n;
    logic [1:0] gst;
    logic [63:0] gchk;

    tbl[0] = '{0, 16'd1, 16'd4, 16'd2, 8'h5A, 8,  64'h1234,            0, 2'd0, 64'h1234};
    tbl[1] = '{1, 16'd3, 16'd0, 16'd5, 8'h11, 8,  64'hDEAD,            0, 2'd1, 64'h0};
    tbl[2] = '{0, 16'd2, 16'd2, 16'd2, 8'h22, 16, 64'hBEEF_0000_0001,  0, 2'd0, 64'hBEEF_0000_0001};
    tbl[3] = '{1, 16'd7, 16'd1, 16'd1, 8'h33, 17, 64'hCAFE,            0, 2'd2, 64'h0};
    tbl[4] = '{0, 16'd1, 16'd1, 16'd1, 8'h44, 1,  64'h1,               2, 2'd0, 64'h1};
    tbl[5] = '{0, 16'd0, 16'd0, 16'd0, 8'h66, 3,  64'h99,              0, 2'd1, 64'h0};
    tbl[6] = '{1, 16'd5, 16'd5, 16'd5, 8'h55, 4,  64'h77,              5, 2'd0, 64'h77};

    for (int r = 0; r < N; r++) begin
      pend[r] = 1'b0; jm[r] = '0; jd[r] = '0; js[r] = '0; jt[r] = '0; jdel[r] = 1; jchk[r] = '0;
    end
    bus.cmd_valid = '0; bus.cmd_m_rows = '0; bus.cmd_head_dim = '0;
    bus.cmd_s_tokens = '0; bus.cmd_tag = '0; bus.rsp_ready = 1'b0;

    // reset state, with requests pending to show cmd_ready is held low
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1; bus.cmd_valid = '1; #1;
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check("rst_core", 64'({bus.core_start, bus.core_m_rows, bus.core_head_dim, bus.core_s_tokens}), 64'd0);
    check("rst_rsp", 64'({bus.rsp_valid, bus.rsp_id, bus.rsp_tag, bus.rsp_status}), 64'd0);
    check("rst_rsp_chk", bus.rsp_checksum, 64'd0);
    check("rst_stats", 64'({bus.stat_jobs, bus.stat_timeouts}), 64'd0);
    bus.cmd_valid = '0;
    step();
    rstn = 1'b1;
    step();

    // directed vectors: basic job, zero job, done on the limit, one past it, stalls
    for (int i = 0; i < 7; i++) begin
      set_job(tbl[i].req, tbl[i].m, tbl[i].d, tbl[i].s, tbl[i].tag, tbl[i].dly, tbl[i].cchk);
      serve_one(tbl[i].stall, gid, gst, gchk);
      check("tbl_id", 64'(gid), 64'(tbl[i].req));
      check("tbl_status", 64'(gst), 64'(tbl[i].est));
      check("tbl_chk", gchk, tbl[i].echk);
    end

    // both requesters valid continuously: grants alternate starting at 0
    for (int j = 0; j < 4; j++) begin
      for (int r = 0; r < N; r++)
        if (!pend[r]) set_job(r, 16'd2, 16'd3, 16'd4, 8'(8'hA0 + j * 2 + r), 3, {$urandom, $urandom});
      serve_one(0, gid, gst, gchk);
      check("rr_order", 64'(gid), 64'(j % 2));
    end
    for (int r = 0; r < N; r++) pend[r] = 1'b0;
    drive_cmds();

    // timeout with the core still busy: no new accept until busy drops
    set_job(0, 16'd3, 16'd3, 16'd3, 8'h77, 40, 64'h5555);
    serve_one(0, gid, gst, gchk);
    set_job(1, 16'd1, 16'd2, 16'd3, 8'h78, 2, 64'h6666);
    drive_cmds(); #1;
    n = 0;
    while (bus.cmd_ready == '0 && n < 100) begin step(); drive_cmds(); #1; n++; end
    check("flush_cycles", 64'(n), 64'd24);
    serve_one(1, gid, gst, gchk);

    // reset in the middle of WAIT: everything clears and the job is dropped
    set_job(0, 16'd4, 16'd4, 16'd4, 8'h90, 60, 64'h1111);
    drive_cmds(); #1;
    n = 0;
    while (bus.cmd_ready == '0 && n < 50) begin step(); drive_cmds(); #1; n++; end
    check("t6_accept", 64'(bus.cmd_ready), 64'd1);
    nxt_delay = 60; nxt_chk = 64'h1111;
    step(); pend[0] = 1'b0; drive_cmds();
    repeat (5) step();
    rstn = 1'b0;
    set_job(0, 16'd1, 16'd1, 16'd1, 8'h91, 2, 64'h2);
    set_job(1, 16'd1, 16'd1, 16'd1, 8'h92, 2, 64'h3);
    drive_cmds(); #1;
    check("t6_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check("t6_core", 64'({bus.core_start, bus.core_m_rows, bus.core_head_dim, bus.core_s_tokens}), 64'd0);
    check("t6_rsp", 64'({bus.rsp_valid, bus.rsp_id, bus.rsp_tag, bus.rsp_status}), 64'd0);
    check("t6_stats", 64'({bus.stat_jobs, bus.stat_timeouts}), 64'd0);
    pend[0] = 1'b0; pend[1] = 1'b0; drive_cmds();
    step();
    rstn = 1'b1;
    mrr = 0; exp_jobs = 0; exp_tmo = 0;
    set_job(1, 16'd6, 16'd6, 16'd6, 8'h93, 5, 64'h4444);
    serve_one(0, gid, gst, gchk);
    check("t6_first", 64'(gid), 64'd1);

    // random traffic against the model
    for (int it = 0; it < 40; it++) begin
      for (int r = 0; r < N; r++) begin
        if (!pend[r] && $urandom_range(0, 1) == 1) begin
          set_job(r,
                  ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 1000)),
                  ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 1000)),
                  ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 1000)),
                  8'($urandom), $urandom_range(1, 24), {$urandom, $urandom});
        end
      end
      if (!pend[0] && !pend[1])
        set_job(0, 16'd9, 16'd9, 16'd9, 8'($urandom), $urandom_range(1, 24), {$urandom, $urandom});
      serve_one($urandom_range(0, 3), gid, gst, gchk);
    end
    for (int r = 0; r < N; r++) pend[r] = 1'b0;
    drive_cmds();
    repeat (3) step();

    check("grant_invariants", 64'(viol), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
